// File: rtl/dc_fifo_din_arbiter_pkg.sv
// Shared definitions for the dual-clock FIFO write-side arbiter.
//
// Contents:
//   state_e   : arbiter FSM encoding (ST_IDLE = 1'b0, ST_LOCKED = 1'b1)
//   rr_winner : rotate-priority pick of the first valid index at or after a
//               pointer, searching upward modulo num_req. It works on
//               vectors of up to 16 requesters; callers zero-extend.
package dc_fifo_din_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int RR_MAX_REQ = 16;

  // The candidate index walks upward from ptr and wraps at num_req-1, so the
  // search never visits codes that do not correspond to a requester. If
  // nothing is valid, ptr is returned; callers qualify with an any-valid flag.
  function automatic logic [3:0] rr_winner(input logic [RR_MAX_REQ-1:0] valid,
                                           input logic [3:0]            ptr,
                                           input int                    num_req);
    logic [3:0] cand;
    logic [3:0] win;
    logic       found;
    cand  = ptr;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < RR_MAX_REQ; k++) begin
      if (k < num_req) begin
        if (!found && valid[cand]) begin
          win   = cand;
          found = 1'b1;
        end
        cand = (cand == 4'(num_req - 1)) ? 4'd0 : cand + 4'd1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dc_rr_pick.sv
// Combinational rotating-priority selector.
//
// Picks the first asserted bit of valid_i at or after rr_ptr_i, wrapping
// from NUM_REQ-1 back to 0. Reusable by read-side schedulers.
//
// Ports:
//   valid_i     : per-requester valid vector
//   rr_ptr_i    : index holding highest priority this cycle
//   winner_o    : selected index (only meaningful when any_valid_o is high)
//   any_valid_o : at least one requester is valid
import dc_fifo_din_arbiter_pkg::*;

module dc_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [ID_WIDTH-1:0] rr_ptr_i,
  output logic [ID_WIDTH-1:0] winner_o,
  output logic                any_valid_o
);

  // Widen to the package helper's fixed 16-bit view and narrow the result
  // back; the helper never returns an index >= NUM_REQ.
  always_comb begin
    winner_o    = ID_WIDTH'(rr_winner(16'(valid_i), 4'(rr_ptr_i), NUM_REQ));
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/dc_fifo_din_arbiter.sv
// Burst-atomic round-robin arbiter in front of a dual-clock FIFO write port.
//
// NUM_REQ requesters share one data/valid/ready sink. A winner keeps the sink
// until its last-flagged beat is accepted; every forwarded beat carries the
// winner index in its upper ID_WIDTH bits so the far domain can demultiplex.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   req_data      : packed payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid     : per-requester valid
//   req_last      : per-requester last-beat flag
//   req_ready     : per-requester ready (only the winner, only when FIFO ready)
//   fifo_data     : {winner id, payload} toward the FIFO
//   fifo_valid    : toward the FIFO
//   fifo_ready    : FIFO not full
//   busy          : a burst is locked
//   cur_id        : registered winner index
//   err_overlong  : sticky flag, a burst ran past MAX_BURST beats
import dc_fifo_din_arbiter_pkg::*;

module dc_fifo_din_arbiter #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int MAX_BURST  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] fifo_data,
  output logic                           fifo_valid,
  input  logic                           fifo_ready,
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            cur_id,
  output logic                           err_overlong
);

  // Counter must hold MAX_BURST+1 so the overrun is observable.
  localparam int                   CNT_W     = $clog2(MAX_BURST + 2);
  localparam logic [CNT_W-1:0]     CNT_SAT   = CNT_W'(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(MAX_BURST);
  localparam logic [ID_WIDTH-1:0]  LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     cur_id_q, cur_id_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    err_q, err_d;

  logic [ID_WIDTH-1:0]     pick_id;
  logic                    pick_any;
  logic                    locked;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    accept;

  dc_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .valid_i     (req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (pick_id),
    .any_valid_o (pick_any)
  );

  // Steer the current winner's valid/last/data through a compare-based mux so
  // ID codes beyond NUM_REQ-1 simply select nothing.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cur_id_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Forwarding path. Outputs are masked by rst so nothing is offered or
  // accepted during reset, including the cycle a mid-burst reset arrives.
  always_comb begin
    locked     = (state_q == ST_LOCKED) && !rst;
    busy       = locked;
    fifo_valid = locked && sel_valid;
    fifo_data  = {cur_id_q, sel_data};
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = locked && fifo_ready && (cur_id_q == ID_WIDTH'(i));
    end
    accept       = fifo_valid && fifo_ready;
    cur_id       = cur_id_q;
    err_overlong = err_q;
  end

  // Next-state logic. IDLE spends one cycle arbitrating; LOCKED holds until
  // the winner's last beat is accepted, regardless of overruns or valid gaps.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          cur_id_d = pick_id;
          state_d  = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          if (sel_last) begin
            state_d    = ST_IDLE;
            rr_ptr_d   = (cur_id_q == LAST_ID) ? '0 : cur_id_q + 1'b1;
            beat_cnt_d = '0;
          end else begin
            if (beat_cnt_q != CNT_SAT) begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
            if (beat_cnt_q >= CNT_LIMIT) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dc_fifo_din_arbiter.sv
// Self-checking bench for dc_fifo_din_arbiter.
//
// Per-requester beat memories feed a driver process; each beat that should
// reach the FIFO is pushed onto an expectation queue in hand-computed grant
// order, and a monitor pops and compares on every accepted FIFO beat.
module tb_dc_fifo_din_arbiter;

  localparam int DW    = 10;
  localparam int NR    = 4;
  localparam int IW    = 2;
  localparam int MB    = 16;
  localparam int DEPTH = 64;

  logic              clk;
  logic              rst;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [DW+IW-1:0]  fifo_data;
  logic              fifo_valid;
  logic              fifo_ready;
  logic              busy;
  logic [IW-1:0]     cur_id;
  logic              err_overlong;

  logic [DW:0]       srcMem [NR][DEPTH];
  int                wr [NR];
  int                rd [NR];
  logic [NR-1:0]     popReq;
  logic [DW+IW-1:0]  expQ [$];

  int                checks   = 0;
  int                errors   = 0;
  int                hsCount  = 0;
  int                stallCnt = 0;
  logic              prevStall;
  logic [DW+IW-1:0]  prevData;

  dc_fifo_din_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_data     (req_data),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_data    (fifo_data),
    .fifo_valid   (fifo_valid),
    .fifo_ready   (fifo_ready),
    .busy         (busy),
    .cur_id       (cur_id),
    .err_overlong (err_overlong)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Queue one beat on a requester; doExpect marks beats that must reach the FIFO.
  task automatic applyStimulus(input int idx, input logic [DW-1:0] payload,
                               input logic last, input bit doExpect);
    srcMem[idx][wr[idx]] = {last, payload};
    wr[idx]++;
    if (doExpect) expQ.push_back({IW'(idx), payload});
  endtask

  function automatic bit srcEmpty();
    bit e = 1'b1;
    for (int i = 0; i < NR; i++) if (rd[i] != wr[i]) e = 1'b0;
    return e;
  endfunction

  // Wait (bounded) for every queued beat to be forwarded and the arbiter idle.
  task automatic waitDrain(input string name);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < 300) begin
      @(posedge clk);
      #2;
      cyc++;
      done = (expQ.size() == 0) && srcEmpty() && !busy;
    end
    checkOutput({name, " drained"}, 32'(done), 32'd1);
  endtask

  // Requester driver: retire handshaken beats and present the next ones
  // shortly after each rising edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (popReq[i]) rd[i]++;
        if (rd[i] < wr[i]) begin
          req_valid[i]           = 1'b1;
          req_last[i]            = srcMem[i][rd[i]][DW];
          req_data[i*DW +: DW]   = srcMem[i][rd[i]][DW-1:0];
        end else begin
          req_valid[i]           = 1'b0;
          req_last[i]            = 1'b0;
          req_data[i*DW +: DW]   = '0;
        end
      end
    end
  end

  // Monitor: on the falling edge compare accepted beats against the queue,
  // check stall stability and quiet outputs during reset.
  initial begin
    logic [DW+IW-1:0] expBeat;
    prevStall = 1'b0;
    prevData  = '0;
    forever begin
      @(negedge clk);
      popReq = req_valid & req_ready;
      if (rst) begin
        checkOutput("reset fifo_valid", 32'(fifo_valid), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stall hold valid", 32'(fifo_valid), 32'd1);
          checkOutput("stall hold data", 32'(fifo_data), 32'(prevData));
        end
        if (fifo_valid && !fifo_ready) begin
          checkOutput("stall req_ready", 32'(req_ready), 32'd0);
          stallCnt++;
        end
        if (fifo_valid && fifo_ready) begin
          hsCount++;
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected beat: actual=%0h required=none", fifo_data);
          end else begin
            expBeat = expQ.pop_front();
            checkOutput("beat", 32'(fifo_data), 32'(expBeat));
          end
        end
        prevStall = fifo_valid && !fifo_ready;
        prevData  = fifo_data;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int seen;
    int base;
    int n;
    int cyc;
    int readyPat [10];
    readyPat = '{1, 0, 0, 1, 0, 1, 1, 0, 0, 1};

    rst        = 1'b1;
    fifo_ready = 1'b1;

    // Reset with all requesters valid, then a continuous single-beat sweep.
    applyStimulus(0, 10'h001, 1'b1, 1'b1);
    applyStimulus(1, 10'h011, 1'b1, 1'b1);
    applyStimulus(2, 10'h021, 1'b1, 1'b1);
    applyStimulus(3, 10'h031, 1'b1, 1'b1);
    applyStimulus(0, 10'h002, 1'b1, 1'b1);
    applyStimulus(1, 10'h012, 1'b1, 1'b1);
    applyStimulus(2, 10'h022, 1'b1, 1'b1);
    applyStimulus(3, 10'h032, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset cur_id", 32'(cur_id), 32'd0);
    checkOutput("reset err", 32'(err_overlong), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checkOutput("bubble busy", 32'(busy), 32'(k % 2));
      if (k == 1) checkOutput("first grant id", 32'(cur_id), 32'd0);
    end
    waitDrain("rr sweep");

    // Three-beat burst on req1 while req2 waits.
    applyStimulus(1, 10'h101, 1'b0, 1'b1);
    applyStimulus(1, 10'h102, 1'b0, 1'b1);
    applyStimulus(1, 10'h103, 1'b1, 1'b1);
    applyStimulus(2, 10'h201, 1'b1, 1'b1);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy && cur_id == 2'd1) begin
        checkOutput("non-winner ready", 32'(req_ready[2]), 32'd0);
        seen++;
      end
    end
    checkOutput("burst lock cycles", 32'(seen), 32'd3);
    waitDrain("atomic burst");

    // Back-pressure during a req3 burst.
    applyStimulus(3, 10'h301, 1'b0, 1'b1);
    applyStimulus(3, 10'h302, 1'b0, 1'b1);
    applyStimulus(3, 10'h303, 1'b1, 1'b1);
    stallCnt = 0;
    for (int k = 0; k < 10; k++) begin
      fifo_ready = readyPat[k][0];
      @(posedge clk);
      #2;
    end
    fifo_ready = 1'b1;
    waitDrain("stall burst");
    checkOutput("stalls observed", 32'(stallCnt != 0), 32'd1);

    // Overlong burst on req0: 17 non-last beats then a last beat.
    base = hsCount;
    for (int k = 0; k < 17; k++) applyStimulus(0, DW'(10'h200 + k), 1'b0, 1'b1);
    applyStimulus(0, 10'h3FF, 1'b1, 1'b1);
    n   = 0;
    cyc = 0;
    while (n < 18 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
      n = hsCount - base;
      checkOutput("overlong flag", 32'(err_overlong), 32'(n >= 17));
      if (n >= 1 && n < 18) begin
        checkOutput("grant held busy", 32'(busy), 32'd1);
        checkOutput("grant held id", 32'(cur_id), 32'd0);
      end
    end
    checkOutput("overlong beats", 32'(n), 32'd18);
    repeat (3) @(posedge clk);
    #2 checkOutput("overlong sticky", 32'(err_overlong), 32'd1);
    waitDrain("overlong");

    // Reset on the second beat of a 4-beat req2 burst.
    applyStimulus(2, 10'h2A1, 1'b0, 1'b1);
    applyStimulus(2, 10'h2A2, 1'b0, 1'b0);
    applyStimulus(2, 10'h2A3, 1'b0, 1'b0);
    applyStimulus(2, 10'h2A4, 1'b1, 1'b0);
    base = hsCount;
    cyc  = 0;
    while ((hsCount - base) < 1 && cyc < 20) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    checkOutput("first beat before reset", 32'(hsCount - base), 32'd1);
    rst   = 1'b1;
    rd[2] = wr[2];
    applyStimulus(0, 10'h0C1, 1'b1, 1'b1);
    applyStimulus(1, 10'h1C1, 1'b1, 1'b1);
    applyStimulus(3, 10'h3C1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("mid reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("after reset busy", 32'(busy), 32'd0);
    checkOutput("after reset cur_id", 32'(cur_id), 32'd0);
    checkOutput("after reset err", 32'(err_overlong), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitDrain("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
